fsoc_wb_arb: RTL

Registered two-master, two-slave Wishbone arbiter for the FazyRV SoC. It shares the single RAM port between the core's instruction bus and data bus with round-robin fairness, and routes data accesses to RAM or GPIO by address. It also guards both buses with a no-ack timeout. It replaces the combinational imem/dmem steering in the SoC top and sits between `fazyrv_top` and the `wb_ram`/`gpio` slaves.

---
 rtl/fsoc_wb_arb.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fsoc_wb_arb.sv
// Two-master (imem/dmem), two-slave (RAM/GPIO) Wishbone arbiter with round-robin
// ties, address-based dmem routing and a no-ack timeout guarding every grant.
module fsoc_wb_arb #(
  parameter int GPIO_BIT = 28,
  parameter int TIMEOUT  = 15
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        imem_stb_i,
  input  logic [31:0] imem_adr_i,
  output logic [31:0] imem_dat_o,
  output logic        imem_ack_o,
  input  logic        dmem_stb_i,
  input  logic        dmem_we_i,
  input  logic [3:0]  dmem_be_i,
  input  logic [31:0] dmem_adr_i,
  input  logic [31:0] dmem_dat_i,
  output logic [31:0] dmem_dat_o,
  output logic        dmem_ack_o,
  output logic        mem_cyc_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_adr_o,
  output logic [31:0] mem_dat_o,
  input  logic [31:0] mem_dat_i,
  input  logic        mem_ack_i,
  output logic        gpio_cyc_o,
  output logic        gpio_stb_o,
  output logic        gpio_we_o,
  output logic [3:0]  gpio_be_o,
  output logic [31:0] gpio_dat_o,
  input  logic [31:0] gpio_dat_i,
  input  logic        gpio_ack_i,
  output logic        tout_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;          // 1: dmem was granted last
  logic          sel_gpio_q, sel_gpio_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tout_q, tout_d;

  logic        gnt_i, gnt_d, to_mem, to_gpio;
  logic        m_stb, s_ack, tmo, m_ack, done;
  logic [31:0] s_dat, req_adr, req_dat;
  logic [3:0]  req_be;
  logic        req_we, req_stb;

  assign gnt_i   = (state_q == GNT_I);
  assign gnt_d   = (state_q == GNT_D);
  assign to_gpio = gnt_d & sel_gpio_q;
  assign to_mem  = gnt_i | (gnt_d & ~sel_gpio_q);

  assign m_stb = gnt_i ? imem_stb_i : (gnt_d & dmem_stb_i);
  assign s_ack = to_gpio ? gpio_ack_i : (to_mem & mem_ack_i);
  assign s_dat = to_gpio ? gpio_dat_i : mem_dat_i;

  // Timeout cycle: the slave request is withdrawn and the master gets a zero-data ack
  assign tmo   = (TIMEOUT != 0) && (state_q != IDLE) && (cnt_q == CW'(TIMEOUT));
  assign m_ack = s_ack | tmo;
  assign done  = s_ack | tmo | ~m_stb;

  assign imem_ack_o = gnt_i & m_ack;
  assign dmem_ack_o = gnt_d & m_ack;
  assign imem_dat_o = (gnt_i & s_ack) ? s_dat : 32'h0;
  assign dmem_dat_o = (gnt_d & s_ack) ? s_dat : 32'h0;

  assign req_stb = m_stb & ~tmo;
  assign req_we  = gnt_d & dmem_we_i;
  assign req_be  = gnt_i ? 4'hF : (gnt_d ? dmem_be_i : 4'h0);
  assign req_adr = gnt_i ? imem_adr_i : (gnt_d ? dmem_adr_i : 32'h0);
  assign req_dat = gnt_d ? dmem_dat_i : 32'h0;

  assign mem_cyc_o = to_mem & req_stb;
  assign mem_stb_o = to_mem & req_stb;
  assign mem_we_o  = to_mem & req_we;
  assign mem_be_o  = to_mem ? req_be  : 4'h0;
  assign mem_adr_o = to_mem ? req_adr : 32'h0;
  assign mem_dat_o = to_mem ? req_dat : 32'h0;

  assign gpio_cyc_o = to_gpio & req_stb;
  assign gpio_stb_o = to_gpio & req_stb;
  assign gpio_we_o  = to_gpio & req_we;
  assign gpio_be_o  = to_gpio ? req_be  : 4'h0;
  assign gpio_dat_o = to_gpio ? req_dat : 32'h0;

  assign tout_o = tout_q;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    sel_gpio_d = sel_gpio_q;
    cnt_d      = cnt_q;
    tout_d     = tout_q;
    case (state_q)
      IDLE: begin
        if (imem_stb_i && (!dmem_stb_i || last_q)) begin
          state_d = GNT_I;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (dmem_stb_i) begin
          state_d    = GNT_D;
          last_d     = 1'b1;
          sel_gpio_d = dmem_adr_i[GPIO_BIT];
          cnt_d      = '0;
        end
      end
      default: begin
        if (done) state_d = IDLE;
        else if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + 1'b1;
        // A real ack in the timeout cycle takes precedence over the flag
        if (tmo && !s_ack) tout_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      sel_gpio_q <= 1'b0;
      cnt_q      <= '0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      sel_gpio_q <= sel_gpio_d;
      cnt_q      <= cnt_d;
      tout_q     <= tout_d;
    end
  end

endmodule
